// File: rtl/knight_pkg.sv
// knight_pkg: mode/direction encodings, reset constants and width helper for the knight scanner family
package knight_pkg;
    typedef enum logic {MODE_BOUNCE = 1'b0, MODE_WRAP = 1'b1} mode_t;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
    localparam dir_t RST_DIR = DIR_UP;
    localparam int   RST_POS = 0;
    // never returns 0 so single-value counters still get a 1-bit register
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/knight_scan_if.sv
// knight_scan_if: control inputs and LED/status outputs of the knight scanner
interface knight_scan_if #(parameter int WIDTH = 8) ();
    localparam int PW = knight_pkg::clog2(WIDTH);
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] out;
    logic             up;
    logic [PW-1:0]    pos;
    logic             step;
    modport master (output en, mode, input out, up, pos, step);
    modport slave  (input en, mode, output out, up, pos, step);
endinterface

// File: rtl/knight_prescaler.sv
// knight_prescaler: enable-gated modulo-DIV counter producing a one-cycle tick every DIV enabled cycles
module knight_prescaler
    import knight_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic ck,
    input  logic res,
    input  logic en,
    output logic tick
);
    localparam int CW = clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = en && (cnt_q == LAST);
    always_comb cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + CW'(1);
    always_ff @(posedge ck or negedge res) begin
        if (!res) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/knight_scan.sv
// knight_scan: Knight Rider head scanner with bounce/wrap modes and prescaled stepping.
// Define KNIGHT_TRAIL_EN to light the TRAIL previous head positions behind the head.
module knight_scan
    import knight_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int TRAIL = 2
) (
    input  logic         ck,
    input  logic         res,
    knight_scan_if.slave bus
);
    localparam int PW = clog2(WIDTH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
    if (WIDTH < 2 || DIV < 1 || TRAIL < 1 || TRAIL > WIDTH - 1) begin : g_bad_param
        $error("knight_scan: illegal parameters");
    end
    logic             tick, at_end;
    logic [PW-1:0]    pos_q, pos_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d, trail;
    logic             step_q;
    knight_prescaler #(.DIV(DIV)) u_pre (
        .ck   (ck),
        .res  (res),
        .en   (bus.en),
        .tick (tick)
    );
    // non-end positions always step; at an end, wrap jumps across and bounce reverses
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        at_end = (dir_q == DIR_UP) ? (pos_q == LAST) : (pos_q == '0);
        if (tick && !at_end)
            pos_d = (dir_q == DIR_UP) ? pos_q + PW'(1) : pos_q - PW'(1);
        else if (tick && mode_t'(bus.mode) == MODE_WRAP)
            pos_d = (dir_q == DIR_UP) ? '0 : LAST;
        else if (tick) begin
            dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            pos_d = (dir_q == DIR_UP) ? LAST - PW'(1) : PW'(1);
        end
    end
`ifdef KNIGHT_TRAIL_EN
    logic [PW-1:0]    hist_q [TRAIL];
    logic [PW-1:0]    hist_d [TRAIL];
    logic [TRAIL-1:0] hv_q, hv_d;
    // valid flags keep cleared history slots from lighting bit 0
    always_comb begin
        hist_d = hist_q;
        hv_d   = hv_q;
        trail  = '0;
        if (tick) begin
            hist_d[0] = pos_q;
            for (int i = 1; i < TRAIL; i++) hist_d[i] = hist_q[i-1];
            hv_d = (hv_q << 1) | TRAIL'(1);
        end
        for (int i = 0; i < TRAIL; i++)
            if (hv_d[i]) trail = trail | (WIDTH'(1) << hist_d[i]);
    end
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            hv_q <= '0;
            for (int i = 0; i < TRAIL; i++) hist_q[i] <= '0;
        end else begin
            hv_q   <= hv_d;
            hist_q <= hist_d;
        end
    end
`else
    assign trail = '0;
`endif
    assign out_d = (WIDTH'(1) << pos_d) | trail;
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            pos_q  <= PW'(RST_POS);
            dir_q  <= RST_DIR;
            out_q  <= WIDTH'(1) << RST_POS;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            out_q  <= out_d;
            step_q <= tick;
        end
    end
    assign bus.pos  = pos_q;
    assign bus.up   = (dir_q == DIR_UP);
    assign bus.out  = out_q;
    assign bus.step = step_q;
endmodule

// File: tb/tb_knight_scan.sv
// tb_knight_scan: directed checks of bounce, wrap, freeze, async reset and prescaling
module tb_knight_scan;
    logic ck  = 1'b0;
    logic res = 1'b0;
    int checks = 0, errors = 0;
    int cur = 0, e1 = -1, e2 = -1;
    always #5 ck = ~ck;
    knight_scan_if #(.WIDTH(8)) b1 ();
    knight_scan_if #(.WIDTH(8)) b3 ();
    knight_scan #(.WIDTH(8), .DIV(1), .TRAIL(2)) u1 (.ck(ck), .res(res), .bus(b1));
    knight_scan #(.WIDTH(8), .DIV(3), .TRAIL(2)) u3 (.ck(ck), .res(res), .bus(b3));

    function automatic logic [7:0] model_out(input int p);
        logic [7:0] o;
        o = 8'd1 << p;
`ifdef KNIGHT_TRAIL_EN
        if (e1 >= 0) o = o | (8'd1 << e1);
        if (e2 >= 0) o = o | (8'd1 << e2);
`endif
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input string tag, input int p, input bit u, input bit s);
        @(posedge ck);
        @(negedge ck);
        if (s) begin
            e2  = e1;
            e1  = cur;
            cur = p;
        end
        chk({tag, ".pos"}, 32'(b1.pos), 32'(p));
        chk({tag, ".up"}, 32'(b1.up), 32'(u));
        chk({tag, ".step"}, 32'(b1.step), 32'(s));
        chk({tag, ".out"}, 32'(b1.out), 32'(model_out(p)));
    endtask

    initial begin
        int seq [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        b1.en = 1'b0; b1.mode = 1'b0;
        b3.en = 1'b0; b3.mode = 1'b0;
        #12;
        chk("rst.out", 32'(b1.out), 32'h01);
        chk("rst.pos", 32'(b1.pos), 32'd0);
        chk("rst.up", 32'(b1.up), 32'd1);
        chk("rst.step", 32'(b1.step), 32'd0);
        chk("rst3.out", 32'(b3.out), 32'h01);
        @(negedge ck);
        res = 1'b1;
        b1.en = 1'b1;
        for (int i = 0; i < 16; i++) adv("bounce", seq[i], (i < 7 || i > 13), 1'b1);
        adv("bounce", 3, 1'b1, 1'b1);
        adv("bounce", 4, 1'b1, 1'b1);
        b1.en = 1'b0;
        for (int i = 0; i < 5; i++) adv("freeze", 4, 1'b1, 1'b0);
        b1.en = 1'b1;
        adv("resume", 5, 1'b1, 1'b1);
        adv("resume", 6, 1'b1, 1'b1);
        adv("resume", 7, 1'b1, 1'b1);
        adv("resume", 6, 1'b0, 1'b1);
        adv("resume", 5, 1'b0, 1'b1);
        #2 res = 1'b0;
        #1;
        chk("async.pos", 32'(b1.pos), 32'd0);
        chk("async.up", 32'(b1.up), 32'd1);
        chk("async.out", 32'(b1.out), 32'h01);
        chk("async.step", 32'(b1.step), 32'd0);
        cur = 0; e1 = -1; e2 = -1;
        @(negedge ck);
        res = 1'b1;
        b1.mode = 1'b1;
        for (int p = 1; p < 8; p++) adv("wrap_up", p, 1'b1, 1'b1);
        adv("wrap_up", 0, 1'b1, 1'b1);
        adv("wrap_up", 1, 1'b1, 1'b1);
        b1.mode = 1'b0;
        for (int p = 2; p < 8; p++) adv("to_bounce", p, 1'b1, 1'b1);
        adv("to_bounce", 6, 1'b0, 1'b1);
        b1.mode = 1'b1;
        for (int p = 5; p >= 0; p--) adv("wrap_dn", p, 1'b0, 1'b1);
        adv("wrap_dn", 7, 1'b0, 1'b1);
        adv("wrap_dn", 6, 1'b0, 1'b1);
        b1.en = 1'b0;
        b3.en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge ck);
            @(negedge ck);
            chk("div3.pos", 32'(b3.pos), 32'(k / 3));
            chk("div3.step", 32'(b3.step), 32'(k % 3 == 0));
        end
        b3.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge ck);
            @(negedge ck);
            chk("div3_frz.pos", 32'(b3.pos), 32'd2);
            chk("div3_frz.step", 32'(b3.step), 32'd0);
        end
        b3.en = 1'b1;
        @(posedge ck);
        @(negedge ck);
        chk("div3_res.pos", 32'(b3.pos), 32'd2);
        chk("div3_res.step", 32'(b3.step), 32'd0);
        @(posedge ck);
        @(negedge ck);
        chk("div3_res.pos", 32'(b3.pos), 32'd3);
        chk("div3_res.step", 32'(b3.step), 32'd1);
`ifdef KNIGHT_TRAIL_EN
        chk("div3_res.out", 32'(b3.out), 32'h0E);
`else
        chk("div3_res.out", 32'(b3.out), 32'h08);
`endif
        @(posedge ck);
        @(negedge ck);
        chk("div3_after.step", 32'(b3.step), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
